// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage: immediate format codes, the
// default bubble instruction and the register index width.
// Configuration macro used by this slice: DECODE_WB_BYPASS_EN
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int          REG_IDX_W     = 5;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

endpackage

// File: rtl/regfile_np.sv
// -----------------------------------------------------------------------------
// regfile_np
// NREGS x XLEN register file, two combinational read ports, one write port.
// x0 reads 0, indices >= NREGS read 0 and are never written. Synchronous
// reset clears every entry and drops any write in the same cycle.
// With DECODE_WB_BYPASS_EN defined a write to a read index is forwarded to
// the read port in the same cycle; otherwise the pre-write value is read.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data   write port
//   rd_idx1/rd_data1  read port 1
//   rd_idx2/rd_data2  read port 2
// -----------------------------------------------------------------------------
module regfile_np
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [REG_IDX_W-1:0] rd_idx1,
    input  logic [REG_IDX_W-1:0] rd_idx2,
    output logic [XLEN-1:0]      rd_data1,
    output logic [XLEN-1:0]      rd_data2
);

    localparam int         IDX_W   = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [XLEN-1:0] regs_r [NREGS];
    logic            wr_ok_s;

    // Write qualification: enabled, not x0, inside the implemented range
    always_comb begin
        wr_ok_s = wr_en && (wr_idx != 5'd0) && ({1'b0, wr_idx} < NREGS_L);
    end

    // Register array: reset clears all entries, otherwise qualified write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_idx[IDX_W-1:0]] <= wr_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Read port 1
    always_comb begin
        rd_data1 = {XLEN{1'b0}};
        if ((rd_idx1 == 5'd0) || ({1'b0, rd_idx1} >= NREGS_L)) begin
            rd_data1 = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (wr_ok_s && (wr_idx == rd_idx1)) begin
            rd_data1 = wr_data;
`endif
        end else begin
            rd_data1 = regs_r[rd_idx1[IDX_W-1:0]];
        end
    end

    // Read port 2
    always_comb begin
        rd_data2 = {XLEN{1'b0}};
        if ((rd_idx2 == 5'd0) || ({1'b0, rd_idx2} >= NREGS_L)) begin
            rd_data2 = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
        end else if (wr_ok_s && (wr_idx == rd_idx2)) begin
            rd_data2 = wr_data;
`endif
        end else begin
            rd_data2 = regs_r[rd_idx2[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// -----------------------------------------------------------------------------
// decode_stage_p
// IF/ID pipeline register, register file read and immediate extension.
// Decode register priority: reset > flush_d > stall_d > load.
// Configuration macro: DECODE_WB_BYPASS_EN (same-cycle W->D forwarding in
// the register file; without it the hazard unit must forward from W).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   pc_f, pcplus4_f, instr_f      fetch outputs
//   stall_d, flush_d              decode register hold / bubble insert
//   imm_src_d                     immediate format select
//   reg_write_w, rd_w, result_w   writeback port
//   valid_d, instr_d, pc_d, pcplus4_d   latched decode slot
//   rd1_d, rd2_d                  rs1/rs2 read data
//   imm_ext_d                     sign-extended immediate
//   reg_err_d                     valid slot references an index >= NREGS
// -----------------------------------------------------------------------------
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          NREGS     = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      pc_f,
    input  logic [XLEN-1:0]      pcplus4_f,
    input  logic [31:0]          instr_f,
    input  logic                 stall_d,
    input  logic                 flush_d,
    input  logic [2:0]           imm_src_d,
    input  logic                 reg_write_w,
    input  logic [REG_IDX_W-1:0] rd_w,
    input  logic [XLEN-1:0]      result_w,
    output logic                 valid_d,
    output logic [31:0]          instr_d,
    output logic [XLEN-1:0]      pc_d,
    output logic [XLEN-1:0]      pcplus4_d,
    output logic [XLEN-1:0]      rd1_d,
    output logic [XLEN-1:0]      rd2_d,
    output logic [XLEN-1:0]      imm_ext_d,
    output logic                 reg_err_d
);

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic            valid_r;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pcplus4_r;
    logic [31:0]     imm32_s;

    // Decode register: bubble on reset/flush, hold on stall, else load
    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            valid_r   <= 1'b0;
            instr_r   <= NOP_INSTR;
            pc_r      <= {XLEN{1'b0}};
            pcplus4_r <= {XLEN{1'b0}};
        end else if (stall_d) begin
            valid_r   <= valid_r;
            instr_r   <= instr_r;
            pc_r      <= pc_r;
            pcplus4_r <= pcplus4_r;
        end else begin
            valid_r   <= 1'b1;
            instr_r   <= instr_f;
            pc_r      <= pc_f;
            pcplus4_r <= pcplus4_f;
        end
    end

    assign valid_d   = valid_r;
    assign instr_d   = instr_r;
    assign pc_d      = pc_r;
    assign pcplus4_d = pcplus4_r;

    regfile_np #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (reg_write_w),
        .wr_idx   (rd_w),
        .wr_data  (result_w),
        .rd_idx1  (instr_r[19:15]),
        .rd_idx2  (instr_r[24:20]),
        .rd_data1 (rd1_d),
        .rd_data2 (rd2_d)
    );

    // Out-of-range index flag; all fields checked regardless of format
    always_comb begin
        if (valid_r) begin
            reg_err_d = ({1'b0, instr_r[19:15]} >= NREGS_L) ||
                        ({1'b0, instr_r[24:20]} >= NREGS_L) ||
                        ({1'b0, instr_r[11:7]}  >= NREGS_L);
        end else begin
            reg_err_d = 1'b0;
        end
    end

    // Immediate assembled at 32 bits, then sign-extended to XLEN
    always_comb begin
        imm32_s = 32'h0000_0000;
        case (imm_src_d)
            IMM_I:   imm32_s = {{20{instr_r[31]}}, instr_r[31:20]};
            IMM_S:   imm32_s = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
            IMM_B:   imm32_s = {{19{instr_r[31]}}, instr_r[31], instr_r[7],
                                instr_r[30:25], instr_r[11:8], 1'b0};
            IMM_J:   imm32_s = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12],
                                instr_r[20], instr_r[30:21], 1'b0};
            IMM_U:   imm32_s = {instr_r[31:12], 12'h000};
            default: imm32_s = 32'h0000_0000;
        endcase
        imm_ext_d = {{(XLEN - 31){imm32_s[31]}}, imm32_s[30:0]};
    end

endmodule
